// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one start/done FPU among NUM_REQ requesters.
//
// Requesters are granted in round-robin order, one operation at a time.
// Each accepted operation runs IDLE -> START -> WAIT -> RESP -> IDLE, and the
// result is returned only to the requester that was granted.
//
// Optional feature macro: FPU_TIMEOUT_EN
//   When defined, a WAIT-state watchdog ends an operation after TIMEOUT_CYCLES
//   cycles without fpu_done. The operation then completes with rsp_error=1 and
//   rsp_result=0. The next fpu_done, which belongs to the abandoned operation,
//   is discarded.
//   When undefined, rsp_error is tied to 0 and WAIT waits for fpu_done indefinitely.
//
// Ports:
//   clock, reset_n         clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot, IDLE only
//   req_a/req_b/req_op     packed operands and opcode, slice i = requester i
//   rsp_valid              one-cycle pulse to the owner of the operation
//   rsp_result/rsp_error   result and watchdog flag, valid with rsp_valid
//   busy, grant_id         state != IDLE, current/last owner index
//   fpu_start              one-cycle start pulse to the FPU
//   fpu_a/fpu_b/fpu_op     registered operands, stable from START through RESP
//   fpu_done/fpu_result    FPU completion pulse and its result
module fpu_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_result,
    output logic                           rsp_error,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           fpu_start,
    output logic [DATA_WIDTH-1:0]          fpu_a,
    output logic [DATA_WIDTH-1:0]          fpu_b,
    output logic [OP_WIDTH-1:0]            fpu_op,
    input  logic                           fpu_done,
    input  logic [DATA_WIDTH-1:0]          fpu_result
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic                  accept;
    logic                  done_eff;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [OP_WIDTH-1:0]   sel_op;

    // Round-robin search: indices above the pointer first, then wrap to the
    // indices at or below it, so the last owner has the lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[i] && (i > int'(rr_ptr_q))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[i] && (i <= int'(rr_ptr_q))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                sel_op = req_op[i*OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    assign accept = (state_q == IDLE) && win_found;

    // req_ready is gated by reset_n so every output reads 0 while reset is held,
    // even with requesters still asserting valid.
    always_comb begin
        req_ready = '0;
        if (accept && reset_n) begin
            req_ready[win_idx] = 1'b1;
        end
    end

`ifdef FPU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             stale_q;
    logic             err_q;

    // A done that arrives after a timeout belongs to the abandoned operation.
    assign done_eff  = fpu_done && !stale_q;
    assign timeout   = (state_q == WAIT) && !done_eff &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_error = (state_q == RESP) && err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            stale_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == START) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (timeout) begin
                stale_q <= 1'b1;
            end else if (fpu_done) begin
                stale_q <= 1'b0;
            end
            if (state_q == WAIT) begin
                err_q <= timeout;
            end
        end
    end
`else
    assign done_eff  = fpu_done;
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (done_eff || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fpu_start = (state_q == START);
    assign busy      = (state_q != IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_op     <= '0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                rr_ptr_q <= win_idx;
                grant_id <= win_idx;
                fpu_a    <= sel_a;
                fpu_b    <= sel_b;
                fpu_op   <= sel_op;
            end
            if (state_q == WAIT) begin
                if (done_eff) begin
                    rsp_result <= fpu_result;
                end else if (timeout) begin
                    rsp_result <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter.
// A behavioural FPU with configurable latency answers fpu_start. A cycle-level
// reference model tracks the round-robin pointer and the busy window of each
// operation (START at +1, RESP at +latency+2, next grant at +latency+3), and
// predicts every output on each cycle.
// The timeout scenario follows FPU_TIMEOUT_EN.
module tb_fpu_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 3;
    localparam int TO = 16;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N*OW-1:0]   req_op;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_result;
    logic              rsp_error, busy, fpu_start, fpu_done;
    logic [1:0]        grant_id;
    logic [DW-1:0]     fpu_a, fpu_b, fpu_result;
    logic [OW-1:0]     fpu_op;

    logic [DW-1:0]     a_arr[N];
    logic [DW-1:0]     b_arr[N];
    logic [OW-1:0]     op_arr[N];

    int checks = 0;
    int failures = 0;

    // reference model state
    int          cyc, ref_ptr, own, start_due, rsp_due, idle_at, spur_cyc, dut_starts;
    int          fpu_lat = 5;
    bit          fpu_silent = 0;
    bit          spur = 0;
    bit          exp_err;
    logic [DW-1:0] own_a, own_b, exp_res, held_res;
    logic [OW-1:0] own_op;
    logic [1:0]    exp_gid;
    int            grants[$];

    // behavioural FPU
    int            fpu_cnt = -1;
    logic          mdl_done = 1'b0;
    logic [DW-1:0] mdl_res = '0;
    logic [DW-1:0] fpu_pend = '0;

    always #5 clock = ~clock;

    assign req_a  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
    assign req_op = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
    assign fpu_done   = mdl_done | spur;
    assign fpu_result = spur ? 32'hDEAD_BEEF : mdl_res;

    fpu_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy), .grant_id(grant_id),
        .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_done(fpu_done), .fpu_result(fpu_result)
    );

    function automatic logic [DW-1:0] res_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        if (a == 32'h4000_0000 && b == 32'h4040_0000 && op == 3'd0) return 32'h40C0_0000; // 2.0*3.0
        return a + b + {29'd0, op};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // FPU answers fpu_latency negedges after seeing fpu_start
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fpu_cnt  = -1;
            mdl_done = 1'b0;
        end else begin
            mdl_done = 1'b0;
            if (fpu_cnt > 0) fpu_cnt--;
            if (fpu_cnt == 0) begin
                mdl_done = 1'b1;
                mdl_res  = fpu_pend;
                fpu_cnt  = -1;
            end
            if (fpu_start && !fpu_silent) begin
                fpu_cnt  = fpu_lat;
                fpu_pend = res_fn(fpu_a, fpu_b, fpu_op);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive req_valid, compare every output with the model,
    // advance the model on a predicted grant.
    task automatic step(input logic [N-1:0] want);
        logic [N-1:0] er, ers;
        int  w;
        bit  due;
        req_valid = want;
        spur = (cyc == spur_cyc);
        #1;
        w  = -1;
        er = '0;
        if (cyc >= idle_at) w = rr_pick(ref_ptr, want);
        if (w >= 0) er[w] = 1'b1;
        due = (cyc == rsp_due);
        ers = '0;
        if (due) begin
            ers[own] = 1'b1;
            held_res = exp_res;
        end
        checks++;
        if (req_ready !== er) begin
            failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
        end
        checks++;
        if (rsp_valid !== ers) begin
            failures++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ers);
        end
        checks++;
        if (rsp_error !== (due && exp_err)) begin
            failures++; $display("FAIL rsp_error cyc=%0d got=%b exp=%b", cyc, rsp_error, due && exp_err);
        end
        checks++;
        if (rsp_result !== held_res) begin
            failures++; $display("FAIL rsp_result cyc=%0d got=%h exp=%h", cyc, rsp_result, held_res);
        end
        checks++;
        if (fpu_start !== (cyc == start_due)) begin
            failures++; $display("FAIL fpu_start cyc=%0d got=%b exp=%b", cyc, fpu_start, cyc == start_due);
        end
        if (cyc == start_due) begin
            checks++;
            if ({fpu_a, fpu_b, fpu_op} !== {own_a, own_b, own_op}) begin
                failures++;
                $display("FAIL fpu_operands cyc=%0d got=%h/%h/%0d exp=%h/%h/%0d",
                         cyc, fpu_a, fpu_b, fpu_op, own_a, own_b, own_op);
            end
        end
        checks++;
        if (busy !== (cyc >= start_due && cyc < idle_at)) begin
            failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cyc >= start_due && cyc < idle_at);
        end
        checks++;
        if (grant_id !== exp_gid) begin
            failures++; $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, exp_gid);
        end
        if (fpu_start === 1'b1) dut_starts++;
        if (w >= 0) begin
            own       = w;
            ref_ptr   = w;
            own_a     = a_arr[w];
            own_b     = b_arr[w];
            own_op    = op_arr[w];
            start_due = cyc + 1;
            grants.push_back(w);
            if (fpu_silent) begin
`ifdef FPU_TIMEOUT_EN
                rsp_due = cyc + TO + 2;
                idle_at = cyc + TO + 3;
                exp_res = '0;
                exp_err = 1'b1;
`else
                rsp_due = -1;
                idle_at = 32'h7fff_ffff;
`endif
            end else begin
                rsp_due = cyc + fpu_lat + 2;
                idle_at = cyc + fpu_lat + 3;
                exp_res = res_fn(own_a, own_b, own_op);
                exp_err = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (w >= 0) begin
            exp_gid   = 2'(w);
            a_arr[w]  = $urandom;
            b_arr[w]  = $urandom;
            op_arr[w] = 3'($urandom);
        end
    endtask

    task automatic drain();
        while (cyc < idle_at && cyc < 5000) step('0);
    endtask

    task automatic do_reset();
        req_valid = '1;
        spur      = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, fpu_start, grant_id, fpu_op, rsp_error} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b rsp=%b busy=%b start=%b gid=%0d op=%0d err=%b",
                     req_ready, rsp_valid, busy, fpu_start, grant_id, fpu_op, rsp_error);
        end
        checks++;
        if ({fpu_a, fpu_b, rsp_result} !== '0) begin
            failures++; $display("FAIL reset_data a=%h b=%h result=%h", fpu_a, fpu_b, rsp_result);
        end
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        req_valid  = '0;
        cyc        = 0;
        ref_ptr    = N - 1;
        start_due  = -1;
        rsp_due    = -1;
        idle_at    = 0;
        spur_cyc   = -1;
        held_res   = '0;
        exp_gid    = '0;
        exp_err    = 1'b0;
        dut_starts = 0;
        fpu_silent = 1'b0;
        grants.delete();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step('0);
    endtask

    task automatic test_single();
        do_reset();
        fpu_lat   = 5;
        a_arr[0]  = 32'h4000_0000;
        b_arr[0]  = 32'h4040_0000;
        op_arr[0] = 3'd0;
        step(4'b0001);
        drain();
        checks++;
        if (rsp_result !== 32'h40C0_0000 || dut_starts != 1) begin
            failures++; $display("FAIL single_op result=%h starts=%0d exp=40c00000/1", rsp_result, dut_starts);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fpu_lat = 4;
        while (grants.size() < 8 && cyc < 2000) step(4'b1111);
        drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= grants.size() || grants[i] != (i % N)) begin
                failures++;
                $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, (i < grants.size()) ? grants[i] : -1, i % N);
            end
        end
        checks++;
        if (dut_starts != grants.size()) begin
            failures++; $display("FAIL rr_starts got=%0d exp=%0d", dut_starts, grants.size());
        end
    endtask

    task automatic test_rr_pair();
        do_reset();
        fpu_lat = 2;
        step(4'b0100);
        drain();
        while (grants.size() < 3 && cyc < 2000) step(4'b1010);
        drain();
        checks++;
        if (grants.size() != 3 || grants[1] != 3 || grants[2] != 1) begin
            failures++; $display("FAIL rr_pair got_n=%0d exp order 2,3,1", grants.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fpu_lat = 20;
        step(4'b0001);
        repeat (5) step('0);
        do_reset();
        fpu_lat = 3;
        step(4'b1111);
        drain();
        checks++;
        if (grants.size() != 1 || grants[0] != 0 || dut_starts != 1) begin
            failures++; $display("FAIL reset_mid_first_grant n=%0d starts=%0d exp grant 0", grants.size(), dut_starts);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        spur_cyc = 1;
        repeat (3) step('0);
        fpu_lat = 3;
        step(4'b0100);
        spur_cyc = rsp_due;
        drain();
        repeat (2) step('0);
        checks++;
        if (dut_starts != 1 || rsp_result !== exp_res) begin
            failures++; $display("FAIL spurious starts=%0d result=%h exp=1/%h", dut_starts, rsp_result, exp_res);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        fpu_silent = 1'b1;
        step(4'b0001);
`ifdef FPU_TIMEOUT_EN
        drain();
        fpu_silent = 1'b0;
        fpu_lat    = 5;
        step(4'b0010);
        spur_cyc = start_due + 1;
        drain();
        checks++;
        if (rsp_result !== res_fn(own_a, own_b, own_op) || dut_starts != 2) begin
            failures++; $display("FAIL timeout_recovery result=%h starts=%0d", rsp_result, dut_starts);
        end
`else
        repeat (1000) step('0);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== '0 || dut_starts != 1) begin
            failures++; $display("FAIL wait_forever busy=%b rsp=%b starts=%0d exp=1/0/1", busy, rsp_valid, dut_starts);
        end
`endif
    endtask

    task automatic test_random();
        bit pend[N];
        logic [N-1:0] want;
        int n;
        do_reset();
        fpu_lat = $urandom_range(1, 6);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i]   = 1'b1;
                        a_arr[i]  = $urandom;
                        b_arr[i]  = $urandom;
                        op_arr[i] = 3'($urandom);
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    pend[i] = 1'b0;
                end
                want[i] = pend[i];
            end
            n = grants.size();
            step(want);
            if (grants.size() > n && $urandom_range(0, 1) == 0) pend[grants[$]] = 1'b0;
        end
        drain();
        checks++;
        if (dut_starts != grants.size()) begin
            failures++; $display("FAIL random_starts got=%0d exp=%0d", dut_starts, grants.size());
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i]  = '0;
            b_arr[i]  = '0;
            op_arr[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_rr_pair();
        test_reset_mid();
        test_spurious();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
